// File: rtl/axis_stim_harness.sv
// AXI-stream stimulus harness: two LFSR-driven source streams (p, u) and a
// result sink that counts frames, checks frame length and folds data into a MISR.

module axis_lfsr_src #(
  parameter int          N       = 16,
  parameter int          DW      = 64,
  parameter int          NFRAMES = 1,
  parameter logic [63:0] SEED    = 64'h1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          run,
  input  logic          rdy,
  output logic          vld,
  output logic [DW-1:0] data,
  output logic          last,
  output logic          fin_nxt
);
  localparam int          BW    = $clog2(N);
  localparam logic [15:0] NF16  = 16'(NFRAMES);
  localparam logic [63:0] SEED0 = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam logic [63:0] TAPS  = 64'hD800_0000_0000_0000;

  logic [63:0]   lfsr;
  logic [BW-1:0] beat;
  logic [15:0]   frames, frames_nxt;
  logic          acc;

  // Right-shifting Galois form of x^64+x^63+x^61+x^60+1
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  assign vld        = run && (frames < NF16);
  assign acc        = vld && rdy;
  assign last       = (beat == BW'(N-1));
  assign data       = lfsr[DW-1:0];
  assign frames_nxt = frames + 16'(acc && last);
  assign fin_nxt    = (frames_nxt >= NF16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr   <= SEED0;
      beat   <= '0;
      frames <= '0;
    end else if (clear) begin
      lfsr   <= SEED0;
      beat   <= '0;
      frames <= '0;
    end else if (acc) begin
      lfsr   <= lfsr_step(lfsr);
      beat   <= last ? '0 : beat + BW'(1);
      frames <= frames_nxt;
    end
  end
endmodule

module axis_stim_harness #(
  parameter int          N         = 16,
  parameter int          QW        = 64,
  parameter int          UW        = 1,
  parameter int          NFRAMES   = 1,
  parameter logic [63:0] PSEED     = 64'hACE1ACE1ACE1ACE1,
  parameter logic [63:0] USEED     = 64'hFEDCBA9876543210,
  parameter logic [QW-1:0] MISR_POLY = '1
) (
  input  logic          clk,
  input  logic          s_rst_n,
  input  logic          start,
  output logic          p_vld,
  input  logic          p_rdy,
  output logic [QW-1:0] p_data,
  output logic          p_last,
  output logic          u_vld,
  input  logic          u_rdy,
  output logic [UW-1:0] u_data,
  output logic          u_last,
  input  logic          z_vld,
  output logic          z_rdy,
  input  logic [QW-1:0] z_data,
  input  logic          z_last,
  output logic          busy,
  output logic          done,
  output logic          err_len,
  output logic [15:0]   z_frames,
  output logic [QW-1:0] signature
);
  localparam int          BW   = $clog2(N);
  localparam logic [15:0] NF16 = 16'(NFRAMES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic          start_ok, run, p_fin_nxt, u_fin_nxt, z_fin_nxt, z_acc, z_end;
  logic [BW-1:0] z_cnt;
  logic [15:0]   z_frames_nxt;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign run      = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign z_rdy    = busy;

  axis_lfsr_src #(.N(N), .DW(QW), .NFRAMES(NFRAMES), .SEED(PSEED)) u_p_src (
    .clk(clk), .rst_n(s_rst_n), .clear(start_ok), .run(run), .rdy(p_rdy),
    .vld(p_vld), .data(p_data), .last(p_last), .fin_nxt(p_fin_nxt)
  );

  axis_lfsr_src #(.N(N), .DW(UW), .NFRAMES(NFRAMES), .SEED(USEED)) u_u_src (
    .clk(clk), .rst_n(s_rst_n), .clear(start_ok), .run(run), .rdy(u_rdy),
    .vld(u_vld), .data(u_data), .last(u_last), .fin_nxt(u_fin_nxt)
  );

  assign z_acc        = z_vld && z_rdy;
  assign z_end        = (z_cnt == BW'(N-1));
  assign z_frames_nxt = z_frames + 16'(z_acc && z_last);
  assign z_fin_nxt    = (z_frames_nxt >= NF16);

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Look-ahead completion flags let RUN go straight to DONE when the last
  // source beat and the last result frame land in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (p_fin_nxt && u_fin_nxt) state_nxt = z_fin_nxt ? DONE : DRAIN;
      DRAIN:      if (z_fin_nxt) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      signature <= '0;
      err_len   <= 1'b0;
      z_cnt     <= '0;
      z_frames  <= '0;
    end else if (start_ok) begin
      signature <= '0;
      err_len   <= 1'b0;
      z_cnt     <= '0;
      z_frames  <= '0;
    end else if (z_acc) begin
      signature <= {signature[QW-2:0], 1'b0}
                 ^ (signature[QW-1] ? MISR_POLY : '0) ^ z_data;
      z_frames  <= z_frames_nxt;
      // Any z_last resyncs the counter so one bad frame does not skew the next
      if (z_last) begin
        z_cnt <= '0;
        if (!z_end) err_len <= 1'b1;
      end else if (z_end) begin
        z_cnt   <= '0;
        err_len <= 1'b1;
      end else begin
        z_cnt <= z_cnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_axis_stim_harness.sv
// Randomized bench for axis_stim_harness: beat-count based model of both
// sources, z loopback/scripted sink traffic, and a MISR reference.

module tb_axis_stim_harness;
  localparam int N = 4, QW = 64, UW = 1, NF = 3, TOT = N * NF;
  localparam logic [63:0] PSEED = 64'hACE1ACE1ACE1ACE1;
  localparam logic [63:0] USEED = 64'hFEDCBA9876543210;

  logic clk = 0, s_rst_n = 0, start = 0;
  logic p_vld, p_rdy = 0, p_last, u_vld, u_rdy = 0, u_last;
  logic [QW-1:0] p_data;
  logic [UW-1:0] u_data;
  logic z_vld = 0, z_rdy, z_last = 0;
  logic [QW-1:0] z_data = '0;
  logic busy, done, err_len;
  logic [15:0] z_frames;
  logic [QW-1:0] signature;

  axis_stim_harness #(.N(N), .QW(QW), .UW(UW), .NFRAMES(NF)) dut (
    .clk(clk), .s_rst_n(s_rst_n), .start(start),
    .p_vld(p_vld), .p_rdy(p_rdy), .p_data(p_data), .p_last(p_last),
    .u_vld(u_vld), .u_rdy(u_rdy), .u_data(u_data), .u_last(u_last),
    .z_vld(z_vld), .z_rdy(z_rdy), .z_data(z_data), .z_last(z_last),
    .busy(busy), .done(done), .err_len(err_len), .z_frames(z_frames),
    .signature(signature)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference model: state expressed as accepted-beat totals ----
  bit m_run = 0, m_err = 0;
  int pk = 0, uk = 0, m_zf = 0, m_zc = 0;
  logic [63:0] lp = PSEED, lu = USEED, m_sig = '0;
  longint cyc = 0;
  logic [63:0] zq_d[$];
  bit          zq_l[$];
  longint      zq_t[$];
  bit loop = 0, z_rand = 0;
  int p_mode = 0, u_mode = 0;

  function automatic logic [63:0] ref_lfsr(input logic [63:0] s);
    logic [63:0] t;
    t = {1'b0, s[63:1]};
    if (s[0]) begin t[63] ^= 1'b1; t[62] ^= 1'b1; t[60] ^= 1'b1; t[59] ^= 1'b1; end
    return t;
  endfunction

  function automatic bit m_busy();
    return m_run && !(pk == TOT && uk == TOT && m_zf >= NF);
  endfunction
  function automatic bit m_done();
    return m_run && (pk == TOT && uk == TOT && m_zf >= NF);
  endfunction

  always @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      m_run = 0; m_err = 0; pk = 0; uk = 0; m_zf = 0; m_zc = 0;
      lp = PSEED; lu = USEED; m_sig = '0;
      zq_d.delete(); zq_l.delete(); zq_t.delete();
    end else begin
      bit b, pa, ua, za;
      cyc++;
      b  = m_busy();
      pa = b && pk < TOT && p_rdy;
      ua = b && uk < TOT && u_rdy;
      za = b && z_vld;
      if (start && !b) begin
        m_run = 1; m_err = 0; pk = 0; uk = 0; m_zf = 0; m_zc = 0;
        lp = PSEED; lu = USEED; m_sig = '0;
      end else begin
        if (pa) begin
          if (loop) begin zq_d.push_back(lp); zq_l.push_back((pk % N) == N-1); zq_t.push_back(cyc + 2); end
          lp = ref_lfsr(lp); pk++;
        end
        if (ua) begin lu = ref_lfsr(lu); uk++; end
        if (za && zq_d.size() > 0) begin
          logic [63:0] d; bit l;
          d = zq_d.pop_front(); l = zq_l.pop_front(); void'(zq_t.pop_front());
          m_sig = (m_sig << 1) ^ (m_sig[63] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0) ^ d;
          if (l) begin
            if (m_zc != N-1) m_err = 1;
            m_zc = 0; m_zf++;
          end else if (m_zc == N-1) begin
            m_err = 1; m_zc = 0;
          end else m_zc++;
        end
      end
    end
  end

  // ---- input drivers ----
  always @(negedge clk) begin
    case (p_mode) 0: p_rdy = 0; 1: p_rdy = 1; 2: p_rdy = ~p_rdy; default: p_rdy = 1'($urandom_range(0, 1)); endcase
    case (u_mode) 0: u_rdy = 0; 1: u_rdy = 1; 2: u_rdy = ~u_rdy; default: u_rdy = 1'($urandom_range(0, 1)); endcase
    if (zq_d.size() > 0 && zq_t[0] <= cyc) begin
      z_vld  = z_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      z_data = zq_d[0];
      z_last = zq_l[0];
    end else begin
      z_vld = 0; z_data = '0; z_last = 0;
    end
  end

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    #2;
    chk("busy", busy, m_busy());
    chk("done", done, m_done());
    chk("z_rdy", z_rdy, m_busy());
    chk("p_vld", p_vld, m_busy() && pk < TOT);
    chk("u_vld", u_vld, m_busy() && uk < TOT);
    chk("p_last", p_last, (pk % N) == N-1);
    chk("u_last", u_last, (uk % N) == N-1);
    chk("p_data", p_data, lp);
    chk("u_data", 64'(u_data), 64'(lu[0]));
    chk("signature", signature, m_sig);
    chk("err_len", err_len, m_err);
    chk("z_frames", 64'(z_frames), 64'(m_zf));
  end

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    #1 chk("done_reached", done, 1'b1);
  endtask

  logic [63:0] golden;

  initial begin
    repeat (3) @(negedge clk);
    #1 chk("rst_busy", busy, 0);
    chk("rst_pdata", p_data, 64'hACE1ACE1ACE1ACE1);
    s_rst_n = 1;

    // unstalled loopback run; pins first beats of the LFSRs
    p_mode = 1; u_mode = 1; loop = 1; z_rand = 0;
    pulse_start();
    #1 chk("first_p", p_data, 64'hACE1ACE1ACE1ACE1);
    chk("first_u", 64'(u_data), 64'h0);
    chk("first_busy", busy, 1);
    @(negedge clk); #1 chk("second_p", p_data, 64'h8E70D670D670D670);
    @(negedge clk); @(negedge clk); #1 chk("p_last_b3", p_last, 1);
    wait_done(200);
    golden = signature;
    chk("golden_vs_model", golden, m_sig);
    chk("zf_final", 64'(z_frames), 64'(NF));
    chk("err_clean", err_len, 0);

    // p_rdy toggling, u unstalled
    p_mode = 2;
    pulse_start();
    wait_done(300);
    chk("sig_toggle", signature, golden);

    // restart from DONE with random backpressure; stray start mid-run
    p_mode = 3; u_mode = 3; z_rand = 1;
    pulse_start();
    #1 chk("sig_cleared", signature, 64'h0);
    repeat (5) @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    wait_done(600);
    chk("sig_random", signature, golden);

    // reset mid-run, then rerun
    pulse_start();
    @(negedge clk); @(negedge clk);
    s_rst_n = 0;
    @(negedge clk); #1 chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pvld", p_vld, 0);
    @(negedge clk); s_rst_n = 1;
    pulse_start();
    #1 chk("rerun_p", p_data, PSEED);
    chk("rerun_busy", busy, 1);
    wait_done(600);
    chk("sig_after_rst", signature, golden);

    // scripted z: first frame ends early on beat 2
    loop = 0; z_rand = 0;
    @(negedge clk);
    zq_d = '{64'h1234, 64'h1, 64'h5, 64'h10, 64'h11, 64'h12, 64'h13, 64'h20, 64'h21, 64'h22, 64'h23};
    zq_l = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    zq_t = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    pulse_start();
    @(negedge clk); #1 chk("sig_1beat", signature, 64'h1234);
    @(negedge clk); #1 chk("sig_2beat", signature, 64'h2469);
    wait_done(600);
    chk("err_set", err_len, 1);
    chk("zf_err_run", 64'(z_frames), 64'(NF));

    // next start clears the sticky error
    loop = 1; z_rand = 1;
    pulse_start();
    #1 chk("err_cleared", err_len, 0);
    wait_done(600);
    chk("sig_final", signature, golden);
    chk("err_final", err_len, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_stim_harness.md
AXIS_STIM_HARNESS -- requirements
Module: axis_stim_harness

Interface
REQ-001 SHALL have parameter N, default 16: coefficients per frame, N >= 2.
REQ-002 SHALL have parameter QW, default 64: p/z data width, 8..64.
REQ-003 SHALL have parameter UW, default 1: u data width, 1..64.
REQ-004 SHALL have parameter NFRAMES, default 1: frames per run, 1..65535.
REQ-005 SHALL have parameters PSEED = 64'hACE1ACE1ACE1ACE1 and USEED = 64'hFEDCBA9876543210: LFSR seeds.
REQ-006 SHALL have parameter MISR_POLY, default all-ones[QW]: signature feedback taps.
REQ-007 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-008 s_rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  one-cycle run request, honoured in IDLE or DONE only.
REQ-010 p_vld out 1, p_rdy in 1, p_data out QW, p_last out 1: p AXI-stream master.
REQ-011 u_vld out 1, u_rdy in 1, u_data out UW, u_last out 1: u AXI-stream master.
REQ-012 z_vld in 1, z_rdy out 1, z_data in QW, z_last in 1: result AXI-stream slave.
REQ-013 busy out 1, done out 1, err_len out 1 (sticky), z_frames out 16, signature out QW.

Function
REQ-014 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN when both p and u have issued NFRAMES frames; DRAIN -> DONE when z_frames == NFRAMES; DONE -> RUN on start.
REQ-015 busy SHALL be 1 in RUN and DRAIN only; done SHALL be 1 in DONE only.
REQ-016 On start, both LFSRs SHALL reload their seeds, and beat counters, frame counters, z_frames, signature and err_len SHALL clear.
REQ-017 Each generator SHALL be a 64-bit Galois LFSR, taps x^64+x^63+x^61+x^60+1; a zero seed SHALL be replaced by 64'h1.
REQ-018 p_data SHALL be LFSR_p[QW-1:0]; u_data SHALL be LFSR_u[UW-1:0]; each LFSR SHALL advance exactly once per accepted beat of its own stream (vld && rdy).
REQ-019 p_vld and u_vld SHALL be 1 in RUN while the stream's frame count < NFRAMES, otherwise 0.
REQ-020 Streams SHALL be independent; backpressure on one SHALL NOT stall the other.
REQ-021 While vld=1 and rdy=0, data, last and vld SHALL hold stable.
REQ-022 Per-stream beat counter SHALL run 0..N-1 and wrap to 0 on an accepted beat; last SHALL be 1 exactly when the count is N-1.
REQ-023 z_rdy SHALL equal busy; z beats are accepted only when z_vld && z_rdy.
REQ-024 On each accepted z beat, signature SHALL become {sig[QW-2:0],1'b0} ^ (sig[QW-1] ? MISR_POLY : 0) ^ z_data.
REQ-025 The z beat counter SHALL run 0..N-1; z_frames SHALL increment on each accepted z_last.
REQ-026 err_len SHALL set when an accepted z_last arrives with the count != N-1, or the count is N-1 without z_last; the counter SHALL resync to 0 on any z_last.
REQ-027 z beats accepted in RUN SHALL count (DUT latency overlap is legal); extra z beats after DONE SHALL be ignored (z_rdy=0).
REQ-028 Simultaneous final p/u acceptance and final z_last SHALL move RUN directly to DONE.
REQ-029 start asserted during RUN or DRAIN SHALL be ignored.

Reset
REQ-030 On s_rst_n=0, asynchronously: state IDLE; all vld/rdy/last, busy, done and err_len 0; counters 0; signature 0; LFSRs at seed.
REQ-031 Reset asserted mid-run SHALL abort with no further handshakes; the first run after deassertion SHALL reproduce the reset-free sequence bit-exactly.

Verification
REQ-032 N=4, QW=64, NFRAMES=1, rdy=1, start -> first p_data = 64'hACE1ACE1ACE1ACE1, first u_data = 0, p_last on beat 3, FSM leaves RUN after 4 beats.
REQ-033 p_rdy toggling 1010..., u_rdy=1 -> u completes 4 beats in 4 cycles, p in 8 cycles; p_data sequence matches the unstalled reference model.
REQ-034 z loopback of p (z=p delayed 2 cycles), NFRAMES=3 -> z_frames=3, done=1, signature equals the model MISR, err_len=0.
REQ-035 z_last on beat 2 with N=4 -> err_len=1 and sticky until next start; next frame counted normally.
REQ-036 Reset pulse during beat 2 of RUN, then start -> busy=1 and p_data restarts at PSEED; signature identical to the REQ-034 golden value.
REQ-037 start in DONE -> signature clears to 0 and the run repeats with an identical final signature.
